// File: rtl/dmem_arbiter.sv
// Shares the data memory between the MEM-stage CPU port and one external requester (EXT).
// Grant is combinational (zero latency); EXT read data returns registered one cycle later; CPU is held off via cpu_stall.
module dmem_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic                  ext_lock,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  input  logic [2:0]            ext_funct3,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  lock_err,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [7:0]          lock_q, lock_d;
  logic                ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                lock_err_q, lock_err_d;

  logic cpu_act;
  logic starved;
  logic lock_expired;
  logic ext_win;
  logic rel_normal;

  assign cpu_act      = cpu_rd | cpu_wr;
  assign starved      = (starve_q == 4'(STARVE_LIMIT));
  assign lock_expired = (lock_q == 8'(LOCK_MAX));

  // Ownership is suppressed while reset is held so nothing reaches memory from EXT.
  always_comb begin
    ext_win = 1'b0;
    if (!reset) begin
      if (state_q == LOCKED) ext_win = ext_req;
      else                   ext_win = ext_req & (~cpu_act | starved);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB;
      starve_q     <= 4'd0;
      lock_q       <= 8'd0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
      lock_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      lock_q       <= lock_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
      lock_err_q   <= lock_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    lock_err_d = 1'b0;
    rel_normal = (ext_win & ~ext_lock) | (~ext_req & ~ext_lock);

    if (ext_win || !ext_req) starve_d = 4'd0;
    else if (!starved)       starve_d = starve_q + 4'd1;
    else                     starve_d = starve_q;

    case (state_q)
      ARB: begin
        if (ext_win && ext_lock) begin
          state_d = LOCKED;
          lock_d  = 8'd1;
        end
      end
      LOCKED: begin
        if (rel_normal) begin
          state_d = ARB;
          lock_d  = 8'd0;
        end else if (lock_expired) begin
          state_d    = ARB;
          lock_d     = 8'd0;
          lock_err_d = 1'b1;
        end else begin
          lock_d = lock_q + 8'd1;
        end
      end
      default: state_d = ARB;
    endcase

    ext_rvalid_d = ext_win & ~ext_we;
    ext_rdata_d  = ext_rvalid_d ? mem_rdata : ext_rdata_q;
  end

  // A stalled CPU keeps its request on the bus but its strobes are masked, so it is only performed once.
  always_comb begin
    ext_gnt   = ext_win;
    cpu_stall = cpu_act & (ext_win | (state_q == LOCKED));
    if (ext_win) begin
      mem_rd     = ~ext_we;
      mem_wr     = ext_we;
      mem_addr   = ext_addr;
      mem_wdata  = ext_wdata;
      mem_funct3 = ext_funct3;
    end else begin
      mem_rd     = cpu_rd & ~cpu_stall;
      mem_wr     = cpu_wr & ~cpu_stall;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_funct3 = cpu_funct3;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;
  assign lock_err   = lock_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a behavioural model,
// with a byte-addressed data memory modelled alongside the DUT.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int LM = 8;

  logic clk = 1'b0;
  logic reset;
  logic cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0] cpu_funct3;
  logic [DW-1:0] cpu_rdata;
  logic cpu_stall;
  logic ext_req, ext_we, ext_lock;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [2:0] ext_funct3;
  logic ext_gnt, ext_rvalid, lock_err;
  logic [DW-1:0] ext_rdata;
  logic mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0] mem_funct3;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_funct3(ext_funct3), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .lock_err(lock_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational load with size/sign, byte/half/word stores on the clock edge.
  logic [7:0] ram [512];
  logic bd_we = 1'b0;
  logic [8:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  function automatic logic [31:0] ld_fmt(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'b0, raw[7:0]};
      3'b101:  return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb mem_rdata = ld_fmt({ram[mem_addr + 9'd3], ram[mem_addr + 9'd2],
                                  ram[mem_addr + 9'd1], ram[mem_addr]}, mem_funct3);

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr]         <= bd_data[7:0];
      ram[bd_addr + 9'd1]  <= bd_data[15:8];
      ram[bd_addr + 9'd2]  <= bd_data[23:16];
      ram[bd_addr + 9'd3]  <= bd_data[31:24];
    end else if (mem_wr) begin
      ram[mem_addr] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) ram[mem_addr + 9'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        ram[mem_addr + 9'd2] <= mem_wdata[23:16];
        ram[mem_addr + 9'd3] <= mem_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] ram_word(input logic [8:0] a);
    return {ram[a + 9'd3], ram[a + 9'd2], ram[a + 9'd1], ram[a]};
  endfunction

  // Reference memory used by the random run's model.
  logic [7:0] ref_mem [512];

  function automatic logic [31:0] ref_rd(input logic [8:0] a, input logic [2:0] f3);
    return ld_fmt({ref_mem[a + 9'd3], ref_mem[a + 9'd2], ref_mem[a + 9'd1], ref_mem[a]}, f3);
  endfunction

  task automatic ref_wr(input logic [8:0] a, input logic [2:0] f3, input logic [31:0] d);
    ref_mem[a] = d[7:0];
    if (f3[1:0] != 2'b00) ref_mem[a + 9'd1] = d[15:8];
    if (f3[1:0] == 2'b10) begin
      ref_mem[a + 9'd2] = d[23:16];
      ref_mem[a + 9'd3] = d[31:24];
    end
  endtask

  function automatic logic [2:0] pick_f3(input int k);
    case (k)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  task automatic idle_in();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b010;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0; ext_funct3 = 3'b010;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_in();
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    cpu_rd = 1; cpu_addr = 9'h0AA; ext_req = 1; ext_addr = 9'h055;
    #2;
    total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0", ext_gnt); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    total++; if (mem_addr !== 9'h0AA || mem_rd !== 1'b1) begin bad++; $display("FAIL reset_mem_follow: got addr %h rd %b want 0aa 1", mem_addr, mem_rd); end
    @(posedge clk); #1;
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0 || lock_err !== 1'b0) begin bad++;
      $display("FAIL reset_regs: got rvalid %b rdata %h err %b want 0 0 0", ext_rvalid, ext_rdata, lock_err); end
    @(negedge clk);
    reset = 1'b0;
    idle_in();
  endtask

  task automatic test_ext_read();
    preload(9'h010, 32'hDEADBEEF);
    @(negedge clk);
    ext_req = 1; ext_we = 0; ext_addr = 9'h010; ext_funct3 = 3'b010;
    #2;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL extrd_gnt: got gnt %b stall %b want 1 0", ext_gnt, cpu_stall); end
    total++; if (mem_rd !== 1'b1 || mem_addr !== 9'h010) begin bad++; $display("FAIL extrd_bus: got rd %b addr %h want 1 010", mem_rd, mem_addr); end
    @(posedge clk); #1;
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL extrd_resp: got %b %h want 1 deadbeef", ext_rvalid, ext_rdata); end
    @(negedge clk);
    idle_in();
    @(posedge clk); #1;
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL extrd_hold: got %b %h want 0 deadbeef", ext_rvalid, ext_rdata); end
  endtask

  task automatic test_starvation();
    logic eg;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cpu_rd = 1; cpu_addr = 9'h040; cpu_funct3 = 3'b010;
      ext_req = 1; ext_we = 0; ext_lock = 0; ext_addr = 9'h080;
      #2;
      eg = (c == 5 || c == 10);
      total++; if (ext_gnt !== eg || cpu_stall !== eg) begin bad++;
        $display("FAIL starve_c%0d: got gnt %b stall %b want %b %b", c, ext_gnt, cpu_stall, eg, eg); end
      total++; if (mem_addr !== (eg ? 9'h080 : 9'h040)) begin bad++;
        $display("FAIL starve_addr_c%0d: got %h want %h", c, mem_addr, eg ? 9'h080 : 9'h040); end
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_locked_rmw();
    preload(9'h020, 32'h11223344);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cpu_rd = 1; cpu_addr = 9'h100; cpu_funct3 = 3'b010;
      ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 9'h020; ext_funct3 = 3'b010;
      #2;
      total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL rmw_pre_c%0d: got gnt %b want 0", c, ext_gnt); end
    end
    @(negedge clk);
    cpu_rd = 0; cpu_wr = 1; cpu_addr = 9'h020; cpu_wdata = 32'h77777777;
    #2;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_rd !== 1'b1 || mem_wr !== 1'b0) begin bad++;
      $display("FAIL rmw_c1: got gnt %b stall %b rd %b wr %b want 1 1 1 0", ext_gnt, cpu_stall, mem_rd, mem_wr); end
    @(posedge clk); #1;
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h11223344) begin bad++; $display("FAIL rmw_rdata: got %b %h want 1 11223344", ext_rvalid, ext_rdata); end
    @(negedge clk);
    ext_req = 0; ext_lock = 1;
    #2;
    total++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b1 || mem_wr !== 1'b0) begin bad++;
      $display("FAIL rmw_c2: got gnt %b stall %b wr %b want 0 1 0", ext_gnt, cpu_stall, mem_wr); end
    @(negedge clk);
    ext_req = 1; ext_we = 1; ext_lock = 0; ext_wdata = 32'h5;
    #2;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 32'h5) begin bad++;
      $display("FAIL rmw_c3: got gnt %b stall %b wr %b wdata %h want 1 1 1 5", ext_gnt, cpu_stall, mem_wr, mem_wdata); end
    @(posedge clk); #1;
    total++; if (ram_word(9'h020) !== 32'h5) begin bad++; $display("FAIL rmw_ext_write: got %h want 5", ram_word(9'h020)); end
    @(negedge clk);
    ext_req = 0; ext_we = 0;
    #2;
    total++; if (cpu_stall !== 1'b0 || mem_wr !== 1'b1 || mem_wdata !== 32'h77777777) begin bad++;
      $display("FAIL rmw_c4: got stall %b wr %b wdata %h want 0 1 77777777", cpu_stall, mem_wr, mem_wdata); end
    @(posedge clk); #1;
    total++; if (ram_word(9'h020) !== 32'h77777777) begin bad++; $display("FAIL rmw_cpu_write: got %h want 77777777", ram_word(9'h020)); end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_lock_timeout();
    @(negedge clk);
    ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 9'h030;
    #2;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL lto_c1: got gnt %b stall %b want 1 0", ext_gnt, cpu_stall); end
    @(posedge clk); #1;
    total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL lto_err_c1: got %b want 0", lock_err); end
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      cpu_wr = 1; cpu_addr = 9'h034; cpu_wdata = 32'hA5A5A5A5; cpu_funct3 = 3'b010;
      #2;
      total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_wr !== 1'b0) begin bad++;
        $display("FAIL lto_c%0d: got gnt %b stall %b wr %b want 1 1 0", c, ext_gnt, cpu_stall, mem_wr); end
      @(posedge clk); #1;
      total++; if (lock_err !== (c == 9)) begin bad++; $display("FAIL lto_err_c%0d: got %b want %b", c, lock_err, c == 9); end
    end
    @(negedge clk);
    #2;
    total++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_wr !== 1'b1) begin bad++;
      $display("FAIL lto_c10: got gnt %b stall %b wr %b want 0 0 1", ext_gnt, cpu_stall, mem_wr); end
    @(posedge clk); #1;
    total++; if (lock_err !== 1'b0 || ram_word(9'h034) !== 32'hA5A5A5A5) begin bad++;
      $display("FAIL lto_after: got err %b word %h want 0 a5a5a5a5", lock_err, ram_word(9'h034)); end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_reset_midlock();
    preload(9'h004, 32'hCAFEF00D);
    @(negedge clk);
    ext_req = 1; ext_we = 0; ext_lock = 1; ext_addr = 9'h030;
    @(negedge clk);
    cpu_rd = 1; cpu_addr = 9'h004; cpu_funct3 = 3'b010;
    #2;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1) begin bad++; $display("FAIL rml_locked: got gnt %b stall %b want 1 1", ext_gnt, cpu_stall); end
    @(posedge clk); #1;
    total++; if (ext_rvalid !== 1'b1) begin bad++; $display("FAIL rml_rvalid_pre: got %b want 1", ext_rvalid); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (cpu_stall !== 1'b0 || ext_gnt !== 1'b0 || ext_rvalid !== 1'b0 || lock_err !== 1'b0) begin bad++;
      $display("FAIL rml_async: got stall %b gnt %b rvalid %b err %b want 0 0 0 0", cpu_stall, ext_gnt, ext_rvalid, lock_err); end
    total++; if (mem_addr !== 9'h004 || mem_rd !== 1'b1) begin bad++; $display("FAIL rml_bus: got addr %h rd %b want 004 1", mem_addr, mem_rd); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ext_req = 0; ext_lock = 0;
    #2;
    total++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hCAFEF00D) begin bad++;
      $display("FAIL rml_cpu_read: got stall %b data %h want 0 cafef00d", cpu_stall, cpu_rdata); end
    @(posedge clk); #1;
    total++; if (lock_err !== 1'b0 || ext_rvalid !== 1'b0) begin bad++; $display("FAIL rml_after: got err %b rvalid %b want 0 0", lock_err, ext_rvalid); end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_byte_write();
    preload(9'h000, 32'h11223344);
    @(negedge clk);
    ext_req = 1; ext_we = 1; ext_addr = 9'h003; ext_wdata = 32'h000000AB; ext_funct3 = 3'b000;
    #2;
    total++; if (ext_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_funct3 !== 3'b000) begin bad++;
      $display("FAIL bw_bus: got gnt %b wr %b f3 %b want 1 1 000", ext_gnt, mem_wr, mem_funct3); end
    @(posedge clk); #1;
    total++; if (ram_word(9'h000) !== 32'hAB223344) begin bad++; $display("FAIL bw_word: got %h want ab223344", ram_word(9'h000)); end
    @(negedge clk);
    idle_in();
    cpu_rd = 1; cpu_addr = 9'h003; cpu_funct3 = 3'b100;
    #2;
    total++; if (cpu_rdata !== 32'h000000AB) begin bad++; $display("FAIL bw_lbu: got %h want 000000ab", cpu_rdata); end
    @(negedge clk);
    cpu_funct3 = 3'b000;
    #2;
    total++; if (cpu_rdata !== 32'hFFFFFFAB) begin bad++; $display("FAIL bw_lb: got %h want ffffffab", cpu_rdata); end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_random();
    bit m_locked, prev_stall, prev_wait, e_win, e_stall, e_rd, e_wr, act;
    int m_wait, m_held, r;
    logic exp_rvalid, exp_err;
    logic [31:0] exp_rdata;
    logic [8:0] e_addr;
    @(negedge clk);
    idle_in();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = ram[i];
    m_locked = 0; m_wait = 0; m_held = 0; prev_stall = 0; prev_wait = 0;
    exp_rvalid = 0; exp_rdata = '0; exp_err = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!prev_stall) begin
        r = $urandom_range(0, 9);
        cpu_rd = (r < 4); cpu_wr = (r >= 4 && r < 7);
        cpu_addr = 9'($urandom); cpu_wdata = $urandom; cpu_funct3 = pick_f3($urandom_range(0, 4));
      end
      if (!prev_wait) begin
        ext_req = ($urandom_range(0, 2) == 0);
        ext_we = $urandom_range(0, 1) == 1;
        ext_lock = m_locked ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
        ext_addr = 9'($urandom); ext_wdata = $urandom; ext_funct3 = pick_f3($urandom_range(0, 4));
      end
      #2;
      act = cpu_rd || cpu_wr;
      e_win = ext_req && (m_locked || !act || m_wait >= SL);
      e_stall = act && (e_win || m_locked);
      e_rd = e_win ? !ext_we : (cpu_rd && !e_stall);
      e_wr = e_win ? ext_we : (cpu_wr && !e_stall);
      e_addr = e_win ? ext_addr : cpu_addr;
      total++; if (ext_gnt !== e_win || cpu_stall !== e_stall) begin bad++;
        $display("FAIL rnd_own_%0d: got gnt %b stall %b want %b %b", n, ext_gnt, cpu_stall, e_win, e_stall); end
      total++; if (mem_rd !== e_rd || mem_wr !== e_wr || mem_addr !== e_addr) begin bad++;
        $display("FAIL rnd_bus_%0d: got rd %b wr %b addr %h want %b %b %h", n, mem_rd, mem_wr, mem_addr, e_rd, e_wr, e_addr); end
      if (e_wr) begin
        total++; if (mem_wdata !== (e_win ? ext_wdata : cpu_wdata) || mem_funct3 !== (e_win ? ext_funct3 : cpu_funct3)) begin bad++;
          $display("FAIL rnd_wdata_%0d: got %h f3 %b", n, mem_wdata, mem_funct3); end
      end
      if (!e_win && !e_stall && cpu_rd) begin
        total++; if (cpu_rdata !== ref_rd(cpu_addr, cpu_funct3)) begin bad++;
          $display("FAIL rnd_cpu_rdata_%0d: got %h want %h", n, cpu_rdata, ref_rd(cpu_addr, cpu_funct3)); end
      end
      @(posedge clk);
      exp_rvalid = e_win && !ext_we;
      if (exp_rvalid) exp_rdata = ref_rd(ext_addr, ext_funct3);
      if (e_win && ext_we) ref_wr(ext_addr, ext_funct3, ext_wdata);
      else if (e_wr) ref_wr(cpu_addr, cpu_funct3, cpu_wdata);
      if (e_win || !ext_req) m_wait = 0; else if (m_wait < SL) m_wait++;
      exp_err = 0;
      if (!m_locked) begin
        if (e_win && ext_lock) begin m_locked = 1; m_held = 1; end
      end else if ((e_win && !ext_lock) || (!ext_req && !ext_lock)) begin
        m_locked = 0;
      end else if (m_held == LM) begin
        m_locked = 0; exp_err = 1;
      end else begin
        m_held++;
      end
      prev_stall = e_stall;
      prev_wait = ext_req && !e_win;
      #1;
      total++; if (ext_rvalid !== exp_rvalid || ext_rdata !== exp_rdata || lock_err !== exp_err) begin bad++;
        $display("FAIL rnd_regs_%0d: got rvalid %b rdata %h err %b want %b %h %b", n, ext_rvalid, ext_rdata, lock_err, exp_rvalid, exp_rdata, exp_err); end
    end
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    test_reset();
    test_ext_read();
    test_starvation();
    test_locked_rmw();
    test_lock_timeout();
    test_reset_midlock();
    test_byte_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between the pipeline MEM stage (CPU port) and one external requester (loader/debug/DMA port, EXT).
- Sits between the EX/MEM register outputs and the datamemory instance.
- Asserts cpu_stall to freeze the pipeline whenever EXT owns the memory while the CPU has an access pending.
- Supports locked multi-cycle EXT ownership for atomic read-modify-write, and starvation-bounded fairness.

Parameters:
- DM_ADDRESS, 9, data memory byte-address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive EXT-denied cycles after which EXT pre-empts the CPU (1..15).
- LOCK_MAX, 8, maximum cycles EXT may hold a lock before forced release (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_rd  in  1  MEM-stage read request.
- cpu_wr  in  1  MEM-stage write request.
- cpu_addr  in  DM_ADDRESS  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_funct3  in  3  CPU access size/sign.
- cpu_rdata  out  DATA_W  read data to the MEM/WB register.
- cpu_stall  out  1  pipeline freeze request.
- ext_req  in  1  EXT access request, held until granted.
- ext_we  in  1  EXT write (1) / read (0).
- ext_lock  in  1  EXT requests to keep ownership after this access.
- ext_addr  in  DM_ADDRESS  EXT address.
- ext_wdata  in  DATA_W  EXT write data.
- ext_funct3  in  3  EXT access size/sign.
- ext_gnt  out  1  EXT access performed this cycle.
- ext_rvalid  out  1  registered read response valid.
- ext_rdata  out  DATA_W  registered read data.
- lock_err  out  1  one-cycle pulse on lock timeout.
- mem_rd, mem_wr  out  1 each  to datamemory.
- mem_addr  out  DM_ADDRESS  to datamemory.
- mem_wdata  out  DATA_W  to datamemory.
- mem_funct3  out  3  to datamemory.
- mem_rdata  in  DATA_W  combinational read data from datamemory.

Behaviour:
- Definitions: cpu_act = cpu_rd | cpu_wr. Memory read is combinational, so every access completes in its grant cycle.
- Registers: state {ARB, LOCKED}, starve_cnt [3:0], lock_cnt [7:0], ext_rvalid, ext_rdata, lock_err.
- Reset (async): state=ARB, both counters=0, ext_rvalid=0, ext_rdata=0, lock_err=0.
- Reset combinational outputs: ext_gnt=0, cpu_stall=0, mem_* follow CPU inputs.
- Ownership in ARB: ext_win = ext_req & (!cpu_act | starve_cnt==STARVE_LIMIT).
- Ownership in LOCKED: ext_win = ext_req.
- EXT owns (ext_win=1): mem_* driven from ext_*, with mem_rd=!ext_we, mem_wr=ext_we. ext_gnt=1. cpu_stall=cpu_act.
- CPU owns (ext_win=0): mem_* driven from cpu_*. ext_gnt=0.
  - cpu_stall=0 in ARB.
  - In LOCKED, cpu_stall=cpu_act even if ext_req=0, because the CPU is blocked for the whole lock.
- cpu_rdata = mem_rdata at all times. It is meaningful only when the CPU owns and is not stalled.
- starve_cnt:
  - Clears when ext_gnt=1 or ext_req=0.
  - Increments, saturating at STARVE_LIMIT, when ext_req & !ext_win.
- ARB->LOCKED: on ext_gnt & ext_lock. lock_cnt loads 1.
- LOCKED->ARB when any of:
  - ext_gnt & !ext_lock (release after the final access);
  - ext_req=0 & ext_lock=0;
  - lock_cnt==LOCK_MAX (forced release).
- Forced release: the access in that cycle is still granted if ext_req. lock_err pulses 1 on the next cycle.
- Otherwise in LOCKED, lock_cnt increments every cycle.
- ext_rvalid <= ext_gnt & !ext_we. ext_rdata <= mem_rdata when granting a read; otherwise ext_rdata holds.
- Stall contract: the pipeline holds EX/MEM contents while cpu_stall=1, so the CPU request is re-presented. No CPU access is ever dropped or duplicated.
- Simultaneous CPU+EXT with starve_cnt<STARVE_LIMIT: CPU wins, no stall.
- Reset mid-lock: immediate return to ARB, ext_rvalid=0, no lock_err.

Test Plan:
1. EXT read only: cpu idle, ext_req=1, ext_we=0, addr=0x010, memory holds 0xDEADBEEF. Required: ext_gnt=1 same cycle, cpu_stall=0; next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF.
2. Contention/starvation: cpu_rd held 1, ext_req held 1. Required: CPU owns 4 cycles, cpu_stall=0; cycle 5 ext_gnt=1, cpu_stall=1, mem_addr=ext_addr; cycle 6 CPU owns again, starve_cnt=0.
3. Locked RMW:
   - Cycle 1: EXT read 0x020 with ext_lock=1.
   - Cycle 2: ext_req=0, lock held.
   - Cycle 3: EXT write 0x020 = 0x5 with ext_lock=0.
   - cpu_wr=1 throughout. Required: cpu_stall=1 cycles 1-3; memory word 0x020=0x5 before the CPU write lands in cycle 4.
4. Lock timeout: ext_lock stuck 1, ext_req=1, LOCK_MAX=8. Required: return to ARB after 8 locked cycles, lock_err=1 for exactly one cycle, CPU write then completes.
5. Async reset asserted mid-lock between clock edges. Required: cpu_stall=0, ext_gnt=0, ext_rvalid=0 immediately; after release CPU read of 0x004 returns stored data.
6. Byte write: EXT write funct3=000, addr=0x003, data=0xAB. Required: mem_funct3=000, only byte 3 changes; a subsequent CPU lbu of 0x003 returns 0x000000AB.
